// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC controller with imem fetch handshake and redirect/flush logic
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exc,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        misalign
);

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_FETCH    = 2'd1,
    ST_WAIT_MEM = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;
  logic [31:0] pending_target_q, pending_target_d;

  logic        redirect;
  logic [31:0] raw_target;
  logic        target_misaligned;
  logic [31:0] redirect_target;

  assign pc_out    = pc_q;
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + 32'd4;

  // Pick the highest-priority redirect and fold misaligned targets onto the exception vector
  always_comb begin
    redirect          = exc | branch_taken | jump;
    raw_target        = jump_target;
    if (exc)               raw_target = EXC_VECTOR;
    else if (branch_taken) raw_target = branch_target;
    target_misaligned = redirect && (raw_target[1:0] != 2'b00);
    redirect_target   = target_misaligned ? EXC_VECTOR : raw_target;
  end

  // Next-state, next-PC and output decode; a redirect in WAIT_MEM is parked until the fetch lands
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pending_d        = pending_q;
    pending_target_d = pending_target_q;
    imem_req         = 1'b0;
    if_valid         = 1'b0;
    flush_if_id      = 1'b0;
    flush_id_ex      = 1'b0;
    misalign         = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect) begin
          pc_d        = redirect_target;
          flush_if_id = 1'b1;
          flush_id_ex = exc | branch_taken | target_misaligned;
          misalign    = target_misaligned;
        end else if (!stall) begin
          imem_req = 1'b1;
          if (imem_ready) begin
            if_valid = 1'b1;
            pc_d     = pc_plus4;
          end else begin
            state_d = ST_WAIT_MEM;
          end
        end
      end
      ST_WAIT_MEM: begin
        imem_req = 1'b1;
        if (redirect) begin
          flush_if_id      = 1'b1;
          flush_id_ex      = exc | branch_taken | target_misaligned;
          misalign         = target_misaligned;
          pending_d        = 1'b1;
          pending_target_d = redirect_target;
        end
        if (imem_ready) begin
          state_d = ST_FETCH;
          if (pending_d) begin
            pc_d      = pending_target_d;
            pending_d = 1'b0;
          end else begin
            if_valid = 1'b1;
            pc_d     = pc_plus4;
          end
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // State register; reset drops any outstanding fetch and parked redirect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_RESET;
      pc_q             <= RESET_VECTOR;
      pending_q        <= 1'b0;
      pending_target_q <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      pending_q        <= pending_d;
      pending_target_q <= pending_target_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EXV = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n, stall, jump, branch_taken, exc, imem_ready;
  logic [31:0] jump_target, branch_target;
  logic        imem_req, if_valid, flush_if_id, flush_id_ex, misalign;
  logic [31:0] imem_addr, pc_out, pc_plus4;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: where the PC is, whether a fetch is outstanding, whether a redirect waits for it
  bit          m_in_reset;
  bit          m_in_flight;
  logic [31:0] m_pc;
  bit          m_has_redirect;
  logic [31:0] m_redirect_pc;

  pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EXV)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target), .exc(exc),
    .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .if_valid(if_valid), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0; exc = 1'b0;
    imem_ready = 1'b1; jump_target = 32'h0; branch_target = 32'h0;
  endtask

  // One cycle: predict outputs from the model, compare mid-cycle, clock, advance the model
  task automatic step(input string tag);
    logic [31:0] dest, want_pc;
    bit want_redirect, bad_align, go_idle_wait;
    bit e_req, e_val, e_fif, e_fie, e_mis;
    bit nxt_flight, nxt_has;
    logic [31:0] nxt_rpc;
    #2;
    want_redirect = exc || branch_taken || jump;
    dest = exc ? EXV : (branch_taken ? branch_target : jump_target);
    bad_align = want_redirect && (dest % 4 != 0);
    if (bad_align) dest = EXV;
    e_req = 0; e_val = 0; e_fif = 0; e_fie = 0; e_mis = 0;
    want_pc = m_pc; nxt_flight = m_in_flight; nxt_has = m_has_redirect; nxt_rpc = m_redirect_pc;
    if (!m_in_reset) begin
      if (want_redirect) begin
        e_fif = 1; e_fie = exc || branch_taken || bad_align; e_mis = bad_align;
      end
      if (m_in_flight) begin
        e_req = 1;
        if (want_redirect) begin nxt_has = 1; nxt_rpc = dest; end
        if (imem_ready) begin
          nxt_flight = 0;
          if (nxt_has) begin want_pc = nxt_rpc; nxt_has = 0; end
          else begin e_val = 1; want_pc = m_pc + 32'd4; end
        end
      end else if (want_redirect) begin
        want_pc = dest;
      end else if (!stall) begin
        e_req = 1;
        if (imem_ready) begin e_val = 1; want_pc = m_pc + 32'd4; end
        else nxt_flight = 1;
      end
    end
    go_idle_wait = 0;
    chk({tag, ".pc_out"}, pc_out, m_pc);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, e_val});
    chk({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, e_fif});
    chk({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, e_fie});
    chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
    @(posedge clk);
    if (!rst_n) begin
      m_in_reset = 1; m_pc = RV; m_in_flight = 0; m_has_redirect = 0;
    end else begin
      m_in_reset = 0; m_pc = want_pc; m_in_flight = nxt_flight;
      m_has_redirect = nxt_has; m_redirect_pc = nxt_rpc;
    end
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    m_in_reset = 1; m_pc = RV; m_in_flight = 0; m_has_redirect = 0; m_redirect_pc = 32'h0;
    @(posedge clk); #1;

    // reset held two clocks, then sequential fetch 0,4,8,C
    step("rst_a");
    chk("rst_pc", pc_out, 32'h0);
    step("rst_b");
    rst_n = 1'b1;
    step("rst_exit");
    chk("seq_pc0", pc_out, 32'h0);
    step("seq0"); chk("seq_pc4", pc_out, 32'h4);
    step("seq1"); chk("seq_pc8", pc_out, 32'h8);
    step("seq2"); chk("seq_pcC", pc_out, 32'hC);
    step("seq3"); chk("seq_pc10", pc_out, 32'h10);

    // branch and jump together: branch wins, both flushes
    branch_taken = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_target = 32'h200;
    step("br_jmp");
    chk("br_jmp_pc", pc_out, 32'h40);
    idle();

    // exception while a fetch waits at 0x20
    jump = 1'b1; jump_target = 32'h20; step("to20"); idle();
    imem_ready = 1'b0; step("w20_c1");
    exc = 1'b1; step("w20_c2_exc");
    exc = 1'b0; step("w20_c3");
    imem_ready = 1'b1; step("w20_arrive");
    chk("exc_wait_pc", pc_out, 32'h80);

    // misaligned jump target folds to the exception vector
    jump = 1'b1; jump_target = 32'h102; step("mis_jump");
    chk("mis_pc", pc_out, 32'h80);
    idle();

    // stall holds the PC and suppresses requests
    jump = 1'b1; jump_target = 32'h8; step("to8"); idle();
    stall = 1'b1; step("stall1"); step("stall2");
    chk("stall_pc", pc_out, 32'h8);
    stall = 1'b0; step("resume");
    chk("resume_pc", pc_out, 32'hC);

    // wrap at the top of the address space, then reset mid-wait
    jump = 1'b1; jump_target = 32'hFFFF_FFFC; step("to_top"); idle();
    chk("top_pc", pc_out, 32'hFFFF_FFFC);
    step("wrap"); chk("wrap_pc", pc_out, 32'h0);
    imem_ready = 1'b0; step("enter_wait");
    rst_n = 1'b0; step("rst_in_wait");
    chk("rst_wait_pc", pc_out, 32'h0);
    chk("rst_wait_req", {31'd0, imem_req}, 32'h0);
    idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n        = ($urandom % 60) != 0;
      stall        = ($urandom % 5) == 0;
      exc          = ($urandom % 16) == 0;
      branch_taken = ($urandom % 8) == 0;
      jump         = ($urandom % 8) == 0;
      imem_ready   = ($urandom % 4) != 0;
      jump_target   = {$urandom, 2'b00} | (($urandom % 6 == 0) ? 32'($urandom % 4) : 32'd0);
      branch_target = {$urandom, 2'b00} | (($urandom % 6 == 0) ? 32'($urandom % 4) : 32'd0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
